lfsr_multi_prng: RTL and testbench

//  Multi-channel pseudo-random generator built on XNOR-feedback Fibonacci LFSRs.
//  NUM_CH independent LFSRs share one clock, one enable and one seed-load handshake.

---
 rtl/lfsr_pkg.sv | 49 ++++
 rtl/lfsr_core.sv | 90 +++++++++
 rtl/lfsr_multi_prng.sv | 83 ++++++++
 tb/tb_lfsr_multi_prng.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and tap table for the multi-channel XNOR LFSR generator.
package lfsr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } fsm_state_e;

  // Tap mask for an n-bit XNOR Fibonacci LFSR; bit k set means tap k+1 of the table.
  function automatic logic [31:0] lfsr_taps(input int unsigned n);
    logic [31:0] mask;
    case (n)
      3:       mask = 32'h0000_0006;
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      6:       mask = 32'h0000_0030;
      7:       mask = 32'h0000_0060;
      8:       mask = 32'h0000_00B8;
      9:       mask = 32'h0000_0110;
      10:      mask = 32'h0000_0240;
      11:      mask = 32'h0000_0500;
      12:      mask = 32'h0000_0829;
      13:      mask = 32'h0000_100D;
      14:      mask = 32'h0000_2015;
      15:      mask = 32'h0000_6000;
      16:      mask = 32'h0000_D008;
      17:      mask = 32'h0001_2000;
      18:      mask = 32'h0002_0400;
      19:      mask = 32'h0004_0023;
      20:      mask = 32'h0009_0000;
      21:      mask = 32'h0014_0000;
      22:      mask = 32'h0030_0000;
      23:      mask = 32'h0042_0000;
      24:      mask = 32'h00E1_0000;
      25:      mask = 32'h0120_0000;
      26:      mask = 32'h0200_0023;
      27:      mask = 32'h0400_0013;
      28:      mask = 32'h0900_0000;
      29:      mask = 32'h1400_0000;
      30:      mask = 32'h2000_0029;
      31:      mask = 32'h4800_0000;
      32:      mask = 32'h8020_0003;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// One LFSR channel: state, XNOR feedback, period counter, lock-up fix and threshold event.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                run_i,
  input  logic                step_i,
  input  logic                load_i,
  input  logic [NUM_BITS-1:0] seed_i,
  input  logic [NUM_BITS-1:0] threshold_i,
  output logic [NUM_BITS-1:0] data_o,
  output logic                event_o,
  output logic                done_o,
  output logic                lockup_o
);

  localparam logic [NUM_BITS-1:0] TapMask = NUM_BITS'(lfsr_taps(NUM_BITS));
  localparam logic [NUM_BITS-1:0] CntMax  = {{(NUM_BITS-1){1'b1}}, 1'b0};
  localparam logic [NUM_BITS-1:0] CntOne  = {{(NUM_BITS-1){1'b0}}, 1'b1};

  logic [NUM_BITS-1:0] state_q, state_d;
  logic [NUM_BITS-1:0] cnt_q, cnt_d;
  logic                event_q, event_d;
  logic                done_q, done_d;
  logic                lockup_q, lockup_d;
  logic                feedback;
  logic                state_wr;

  assign feedback = ~^(state_q & TapMask);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    event_d  = event_q;
    done_d   = 1'b0;
    lockup_d = 1'b0;
    state_wr = 1'b1;
    if (clear_i) begin
      state_d = '0;
      cnt_d   = '0;
    end else if (load_i) begin
      state_d = seed_i;
      cnt_d   = '0;
    end else if (run_i && (state_q == '1)) begin
      // All-ones never leaves under XNOR feedback, so kick it back to zero.
      state_d  = '0;
      cnt_d    = '0;
      lockup_d = 1'b1;
    end else if (step_i) begin
      state_d = {state_q[NUM_BITS-2:0], feedback};
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end else begin
      state_wr = 1'b0;
    end
    if (state_wr) begin
      event_d = (state_d < threshold_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= '0;
      cnt_q    <= '0;
      event_q  <= 1'b0;
      done_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      event_q  <= event_d;
      done_q   <= done_d;
      lockup_q <= lockup_d;
    end
  end

  assign data_o   = state_q;
  assign event_o  = event_q;
  assign done_o   = done_q;
  assign lockup_o = lockup_q;

endmodule

// File: rtl/lfsr_multi_prng.sv
// Multi-channel XNOR LFSR generator: shared FSM, seed handshake and per-channel seed rotation.
module lfsr_multi_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS = 16,
  parameter int unsigned NUM_CH   = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Enable,
  input  logic                       i_Clear,
  input  logic                       i_Seed_Valid,
  output logic                       o_Seed_Ready,
  input  logic [NUM_BITS-1:0]        i_Seed_Data,
  input  logic [NUM_BITS-1:0]        i_Threshold,
  output logic [NUM_CH*NUM_BITS-1:0] o_LFSR_Data,
  output logic [NUM_CH-1:0]          o_Event,
  output logic [NUM_CH-1:0]          o_Period_Done,
  output logic [NUM_CH-1:0]          o_Lockup,
  output logic                       o_Busy
);

  fsm_state_e state_q, state_d;
  logic       seed_hs;
  logic       core_run;
  logic       core_step;

  assign o_Seed_Ready = (state_q != StLoad);
  assign o_Busy       = (state_q == StRun);
  assign seed_hs      = i_Seed_Valid & o_Seed_Ready;
  assign core_run     = o_Busy & ~i_Clear & ~seed_hs;
  assign core_step    = core_run & i_Enable;

  always_comb begin
    state_d = state_q;
    if (i_Clear) begin
      state_d = StIdle;
    end else if (seed_hs) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle:  if (i_Enable) state_d = StRun;
        StLoad:  state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned Rot = c % NUM_BITS;
    logic [NUM_BITS-1:0] seed_rot;

    // Rotate left; with Rot == 0 the right shift yields zero and the seed passes through.
    assign seed_rot = (i_Seed_Data << Rot) | (i_Seed_Data >> (NUM_BITS - Rot));

    lfsr_core #(
      .NUM_BITS (NUM_BITS)
    ) u_core (
      .clk_i       (i_Clk),
      .rst_i       (i_Rst),
      .clear_i     (i_Clear),
      .run_i       (core_run),
      .step_i      (core_step),
      .load_i      (seed_hs),
      .seed_i      (seed_rot),
      .threshold_i (i_Threshold),
      .data_o      (o_LFSR_Data[c*NUM_BITS +: NUM_BITS]),
      .event_o     (o_Event[c]),
      .done_o      (o_Period_Done[c]),
      .lockup_o    (o_Lockup[c])
    );
  end

endmodule

// File: tb/tb_lfsr_multi_prng.sv
// Self-checking bench for lfsr_multi_prng (4-bit, 2 channels) against a behavioural model.
module tb_lfsr_multi_prng;

  localparam int NB = 4;
  localparam int NC = 2;

  logic       clk = 1'b0;
  logic       rst, en, clr, sv, sr, busy;
  logic [3:0] sd, thr;
  logic [7:0] data;
  logic [1:0] ev, pd, lk;

  lfsr_multi_prng #(
    .NUM_BITS (NB),
    .NUM_CH   (NC)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Enable      (en),
    .i_Clear       (clr),
    .i_Seed_Valid  (sv),
    .o_Seed_Ready  (sr),
    .i_Seed_Data   (sd),
    .i_Threshold   (thr),
    .o_LFSR_Data   (data),
    .o_Event       (ev),
    .o_Period_Done (pd),
    .o_Lockup      (lk),
    .o_Busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: 0 idle, 1 load, 2 run; steps counted since last seed/clear/fix.
  int m_st;
  int m_data  [NC];
  int m_steps [NC];
  bit m_ev    [NC];
  bit m_done  [NC];
  bit m_lock  [NC];

  logic [3:0] exp1 [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6};
  logic       exp4 [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  // Taps 4 and 3, XNOR feedback shifted into bit 0.
  function automatic int lfsr_next(int s);
    int fb;
    fb = (((s >> 3) & 1) == ((s >> 2) & 1)) ? 1 : 0;
    return ((s * 2) % 16) + fb;
  endfunction

  function automatic int rotl(int s, int r);
    int k;
    k = r % NB;
    return ((s << k) | (s >> (NB - k))) & 15;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    for (int c = 0; c < NC; c++) begin
      m_data[c] = 0; m_steps[c] = 0; m_ev[c] = 0; m_done[c] = 0; m_lock[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit hs;
    hs = sv && (m_st != 1);
    for (int c = 0; c < NC; c++) begin
      m_done[c] = 0;
      m_lock[c] = 0;
    end
    if (clr) begin
      m_st = 0;
      for (int c = 0; c < NC; c++) begin
        m_data[c] = 0; m_steps[c] = 0; m_ev[c] = (0 < int'(thr));
      end
    end else if (hs) begin
      m_st = 1;
      for (int c = 0; c < NC; c++) begin
        m_data[c] = rotl(int'(sd), c); m_steps[c] = 0; m_ev[c] = (m_data[c] < int'(thr));
      end
    end else begin
      if (m_st == 2) begin
        for (int c = 0; c < NC; c++) begin
          if (m_data[c] == 15) begin
            m_data[c] = 0; m_steps[c] = 0; m_lock[c] = 1; m_ev[c] = (0 < int'(thr));
          end else if (en) begin
            m_data[c] = lfsr_next(m_data[c]);
            m_steps[c]++;
            if (m_steps[c] == 15) begin
              m_steps[c] = 0;
              m_done[c] = 1;
            end
            m_ev[c] = (m_data[c] < int'(thr));
          end
        end
      end
      if ((m_st == 0 && en) || m_st == 1) m_st = 2;
    end
  endtask

  task automatic check_all(string tag);
    logic [7:0] ed;
    logic [1:0] ee, edn, el;
    for (int c = 0; c < NC; c++) begin
      ed[c*4 +: 4] = 4'(m_data[c]);
      ee[c]  = m_ev[c];
      edn[c] = m_done[c];
      el[c]  = m_lock[c];
    end
    chk({tag, "_data"},  32'(data), 32'(ed));
    chk({tag, "_event"}, 32'(ev),   32'(ee));
    chk({tag, "_done"},  32'(pd),   32'(edn));
    chk({tag, "_lock"},  32'(lk),   32'(el));
    chk({tag, "_busy"},  32'(busy), 32'(m_st == 2));
    chk({tag, "_ready"}, 32'(sr),   32'(m_st != 1));
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; sv = 1'b0; sd = 4'h0; thr = 4'h0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset_ready", 32'(sr), 32'd1);
    rst = 1'b0;

    // 1: free-run from zero; the first enable only enters RUN.
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle("t1");
      chk("t1_ch0", 32'(data[3:0]), 32'(exp1[i]));
      chk("t1_busy", 32'(busy), 32'd1);
    end

    // 2: seed 1 in RUN, then a full period.
    sv = 1'b1; sd = 4'h1;
    cycle("t2_hs");
    sv = 1'b0;
    chk("t2_ready0", 32'(sr), 32'd0);
    chk("t2_seed", 32'(data), 32'h21);
    cycle("t2_load");
    chk("t2_ready1", 32'(sr), 32'd1);
    chk("t2_noload_step", 32'(data), 32'h21);
    for (int i = 0; i < 15; i++) begin
      cycle("t2_run");
      if (i == 14) begin
        chk("t2_done", 32'(pd), 32'h3);
        chk("t2_back", 32'(data), 32'h21);
      end else begin
        chk("t2_nodone", 32'(pd), 32'h0);
      end
    end
    cycle("t2_after");
    chk("t2_pulse_end", 32'(pd), 32'h0);

    // 3: all-ones seed is loaded, then corrected on the first RUN edge.
    sv = 1'b1; sd = 4'hF; en = 1'b0;
    cycle("t3_hs");
    sv = 1'b0;
    cycle("t3_load");
    chk("t3_ff", 32'(data), 32'hFF);
    cycle("t3_fix");
    chk("t3_zero", 32'(data), 32'h00);
    chk("t3_lock", 32'(lk), 32'h3);
    en = 1'b1;
    cycle("t3_step");
    chk("t3_lock_end", 32'(lk), 32'h0);
    chk("t3_restart", 32'(data), 32'h11);

    // 4: threshold event from zero.
    thr = 4'h8; clr = 1'b1;
    cycle("t4_clr");
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle("t4");
      chk("t4_ev0", 32'(ev[0]), 32'(exp4[i]));
    end

    // 5: handshake beats enable; clear beats handshake.
    sv = 1'b1; sd = 4'h3;
    cycle("t5_hs");
    chk("t5_seed", 32'(data), 32'h63);
    sv = 1'b0;
    cycle("t5_load");
    clr = 1'b1; sv = 1'b1; sd = 4'h5;
    cycle("t5_clr");
    chk("t5_clr_data", 32'(data), 32'h00);
    chk("t5_clr_busy", 32'(busy), 32'd0);
    clr = 1'b0; sv = 1'b0;
    for (int i = 0; i < 5; i++) cycle("t5_run");

    // 6: asynchronous reset mid-RUN.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("t6_post");
      chk("t6_no_pulse", 32'({pd, lk}), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      sv  = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 40) == 0);
      sd  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 15) == 0) thr = 4'($urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
